// File: rtl/pipe_alu_regbank_p.sv
// Four-stage ALU pipeline: operand read with full forwarding, ALU, regbank write-back, data-memory write.
// Optional multiplier for func 2 is built only when ALU_MUL_EN is defined; otherwise func 2 is illegal.
module pipe_alu_regbank_p #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 8,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [RA_W-1:0]   rd,
  input  logic [3:0]        func,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wb_en,
  input  logic              mem_en,
  output logic [DATA_W-1:0] zout,
  output logic              zout_valid,
  output logic              flag_zero,
  output logic              flag_neg,
  output logic              illegal,
  input  logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_rdata
);

  function automatic logic func_legal(input logic [3:0] f);
    logic ok;
    case (f)
`ifdef ALU_MUL_EN
      4'd2:         ok = 1'b1;
`else
      4'd2:         ok = 1'b0;
`endif
      4'd14, 4'd15: ok = 1'b0;
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  logic [DATA_W-1:0] r_bank [NREGS];
  logic [DATA_W-1:0] r_mem  [2**ADDR_W];

  logic              r_s1_v, r_s1_wb, r_s1_mem;
  logic [DATA_W-1:0] r_s1_a, r_s1_b;
  logic [RA_W-1:0]   r_s1_rd;
  logic [3:0]        r_s1_func;
  logic [ADDR_W-1:0] r_s1_addr;

  logic              r_s2_v, r_s2_ill, r_s2_wb, r_s2_mem;
  logic [DATA_W-1:0] r_s2_res;
  logic [RA_W-1:0]   r_s2_rd;
  logic [ADDR_W-1:0] r_s2_addr;

  logic              r_s3_mem;
  logic [ADDR_W-1:0] r_s3_addr;

  logic              w_s1_legal, w_s1_fwd;
  logic [DATA_W-1:0] w_alu, w_s1_res, w_op_a, w_op_b;

  // ALU on the S1 operand/control registers
  always_comb begin
    w_s1_legal = func_legal(r_s1_func);
    w_alu      = '0;
    case (r_s1_func)
      4'd0:    w_alu = r_s1_a + r_s1_b;
      4'd1:    w_alu = r_s1_a - r_s1_b;
`ifdef ALU_MUL_EN
      4'd2:    w_alu = r_s1_a * r_s1_b;
`endif
      4'd3:    w_alu = r_s1_a;
      4'd4:    w_alu = r_s1_b;
      4'd5:    w_alu = r_s1_a & r_s1_b;
      4'd6:    w_alu = r_s1_a | r_s1_b;
      4'd7:    w_alu = r_s1_a ^ r_s1_b;
      4'd8:    w_alu = ~r_s1_a;
      4'd9:    w_alu = ~r_s1_b;
      4'd10:   w_alu = {1'b0, r_s1_a[DATA_W-1:1]};
      4'd11:   w_alu = {r_s1_a[DATA_W-2:0], 1'b0};
      4'd12:   w_alu = {r_s1_a[DATA_W-1], r_s1_a[DATA_W-1:1]};
      4'd13:   w_alu = DATA_W'(r_s1_addr);
      default: w_alu = '0;
    endcase
    w_s1_fwd = r_s1_v & r_s1_wb & w_s1_legal;
    if (r_s1_v && w_s1_legal) begin
      w_s1_res = w_alu;
    end else begin
      w_s1_res = '0;
    end
  end

  // Operand select: S1 live result, then S2 result (covers same-edge write-back), then regbank
  always_comb begin
    if (w_s1_fwd && r_s1_rd == rs1) begin
      w_op_a = w_alu;
    end else if (r_s2_wb && r_s2_rd == rs1) begin
      w_op_a = r_s2_res;
    end else begin
      w_op_a = r_bank[rs1];
    end
    if (w_s1_fwd && r_s1_rd == rs2) begin
      w_op_b = w_alu;
    end else if (r_s2_wb && r_s2_rd == rs2) begin
      w_op_b = r_s2_res;
    end else begin
      w_op_b = r_bank[rs2];
    end
  end

  // Pipeline stages S1..S3 and regbank write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_wb    <= 1'b0;
      r_s1_mem   <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_rd    <= '0;
      r_s1_func  <= 4'd0;
      r_s1_addr  <= '0;
      r_s2_v     <= 1'b0;
      r_s2_ill   <= 1'b0;
      r_s2_wb    <= 1'b0;
      r_s2_mem   <= 1'b0;
      r_s2_res   <= '0;
      r_s2_rd    <= '0;
      r_s2_addr  <= '0;
      r_s3_mem   <= 1'b0;
      r_s3_addr  <= '0;
      zout       <= '0;
      zout_valid <= 1'b0;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_bank[i] <= '0;
    end else begin
      r_s1_v     <= in_valid;
      r_s1_wb    <= wb_en;
      r_s1_mem   <= mem_en;
      r_s1_a     <= w_op_a;
      r_s1_b     <= w_op_b;
      r_s1_rd    <= rd;
      r_s1_func  <= func;
      r_s1_addr  <= addr;

      r_s2_v     <= r_s1_v;
      r_s2_ill   <= r_s1_v & ~w_s1_legal;
      r_s2_wb    <= w_s1_fwd;
      r_s2_mem   <= r_s1_v & r_s1_mem & w_s1_legal;
      r_s2_res   <= w_s1_res;
      r_s2_rd    <= r_s1_rd;
      r_s2_addr  <= r_s1_addr;

      r_s3_mem   <= r_s2_mem;
      r_s3_addr  <= r_s2_addr;
      zout       <= r_s2_res;
      zout_valid <= r_s2_v & ~r_s2_ill;
      flag_zero  <= r_s2_v & ~r_s2_ill & (r_s2_res == '0);
      flag_neg   <= r_s2_res[DATA_W-1];
      illegal    <= r_s2_ill;
      if (r_s2_wb) r_bank[r_s2_rd] <= r_s2_res;
    end
  end

  // S4 memory write and read-before-write read port; array contents survive reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
    end else begin
      mem_rdata <= r_mem[mem_raddr];
      if (r_s3_mem) r_mem[r_s3_addr] <= zout;
    end
  end

endmodule

// File: tb/tb_pipe_alu_regbank_p.sv
// Scoreboard bench for pipe_alu_regbank_p: an architectural register model predicts each result at issue.
module tb_pipe_alu_regbank_p;

  logic        clk = 1'b0;
  logic        rst, in_valid, wb_en, mem_en;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, mem_raddr;
  logic [15:0] zout, mem_rdata;
  logic        zout_valid, flag_zero, flag_neg, illegal;

  pipe_alu_regbank_p #(.DATA_W(16), .NREGS(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .wb_en(wb_en), .mem_en(mem_en), .zout(zout),
    .zout_valid(zout_valid), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .illegal(illegal), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] z;
    logic        zv;
    logic        il;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] mreg [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_legal(input logic [3:0] f);
    if (f == 4'd14 || f == 4'd15) return 1'b0;
`ifndef ALU_MUL_EN
    if (f == 4'd2) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_alu(input logic [3:0] f, input logic [15:0] a,
                                            input logic [15:0] b, input logic [7:0] imm);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a;
      4'd4:    return b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return ~a;
      4'd9:    return ~b;
      4'd10:   return a >> 1;
      4'd11:   return a << 1;
      4'd12:   return 16'($signed(a) >>> 1);
      4'd13:   return {8'h00, imm};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check_val("zout", zout, e.z);
      check_val("zout_valid", zout_valid, e.zv);
      check_val("illegal", illegal, e.il);
      check_val("flag_zero", flag_zero, e.zv && (e.z == 16'h0000));
      check_val("flag_neg", flag_neg, e.z[15]);
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [7:0] a, input logic wb, input logic me);
    exp_t        e;
    logic        lg;
    logic [15:0] r;
    rst = 1'b0; in_valid = 1'b1; func = f; rd = d; rs1 = s1; rs2 = s2;
    addr = a; wb_en = wb; mem_en = me;
    lg = model_legal(f);
    r  = lg ? model_alu(f, mreg[s1], mreg[s2], a) : 16'h0000;
    e.due = cyc + 3; e.z = r; e.zv = lg; e.il = ~lg;
    sbq.push_back(e);
    if (lg && wb) mreg[d] = r;
    step();
  endtask

  task automatic bubble();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0; mem_en = 1'b0;
    step();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    sbq.delete();
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0; mem_en = 1'b0;
    check_val({tag, "_zout"}, zout, 16'h0000);
    check_val({tag, "_zout_valid"}, zout_valid, 1'b0);
    check_val({tag, "_flag_zero"}, flag_zero, 1'b0);
    check_val({tag, "_flag_neg"}, flag_neg, 1'b0);
    check_val({tag, "_illegal"}, illegal, 1'b0);
    check_val({tag, "_mem_rdata"}, mem_rdata, 16'h0000);
  endtask

  initial begin
    in_valid = 1'b0; wb_en = 1'b0; mem_en = 1'b0; func = 4'd0;
    rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; addr = 8'h00; mem_raddr = 8'h10;
    rst = 1'b1;
    @(posedge clk);
    do_reset("rst");

    // preload mem[0x10] = 0x0010 (LDI immediate doubles as the write address)
    issue(4'd13, 4'd8, 4'd0, 4'd0, 8'h10, 1'b0, 1'b1);
    // forwarding chain
    issue(4'd13, 4'd1, 4'd0, 4'd0, 8'h05, 1'b1, 1'b0);
    issue(4'd13, 4'd2, 4'd0, 4'd0, 8'h03, 1'b1, 1'b0);
    issue(4'd0,  4'd3, 4'd1, 4'd2, 8'h00, 1'b1, 1'b0);
    issue(4'd1,  4'd4, 4'd2, 4'd1, 8'h00, 1'b1, 1'b0);
    issue(4'd12, 4'd5, 4'd4, 4'd0, 8'h00, 1'b1, 1'b0);
    issue(4'd10, 4'd9, 4'd4, 4'd0, 8'h00, 1'b1, 1'b0);
    issue(4'd7,  4'd10, 4'd1, 4'd1, 8'h00, 1'b1, 1'b0);
    issue(4'd11, 4'd11, 4'd1, 4'd0, 8'h00, 1'b1, 1'b0);
    check_val("r3_model", mreg[3], 16'h0008);

    // memory write at t+3, same-edge read returns old word
    issue(4'd0, 4'd12, 4'd1, 4'd2, 8'h10, 1'b0, 1'b1);
    bubble();
    bubble();
    bubble();
    check_val("mem_same_edge", mem_rdata, 16'h0010);
    bubble();
    check_val("mem_after_write", mem_rdata, 16'h0008);

    // illegal op: no regbank or memory write
    issue(4'd14, 4'd3, 4'd1, 4'd2, 8'h10, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) bubble();
    check_val("mem_no_illegal_write", mem_rdata, 16'h0008);
    issue(4'd3, 4'd0, 4'd3, 4'd0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(12, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      if ((i % 5) == 4) bubble();
    end

    // multiply (illegal when the multiplier is not built)
    issue(4'd13, 4'd6, 4'd0, 4'd0, 8'h80, 1'b1, 1'b0);
    issue(4'd2,  4'd7, 4'd6, 4'd6, 8'h00, 1'b1, 1'b0);
    issue(4'd3,  4'd0, 4'd7, 4'd0, 8'h00, 1'b0, 1'b0);

    // three in flight, oldest would write mem[0x10] on the reset edge
    issue(4'd0,  4'd3, 4'd3, 4'd3, 8'h10, 1'b1, 1'b1);
    issue(4'd4,  4'd9, 4'd0, 4'd3, 8'h00, 1'b1, 1'b0);
    issue(4'd13, 4'd10, 4'd0, 4'd0, 8'h10, 1'b1, 1'b1);
    in_valid = 1'b1; func = 4'd13; rd = 4'd11; wb_en = 1'b1; mem_en = 1'b1; addr = 8'h10;
    do_reset("rst_mid");
    for (int r = 0; r < 16; r++) issue(4'd3, 4'd0, 4'(r), 4'd0, 8'h00, 1'b0, 1'b0);
    bubble();
    check_val("mem_kept_after_rst", mem_rdata, 16'h0008);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) bubble();
    check_val("sb_drain", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
